// File: rtl/control_pkg.sv
// Shared definitions for the multi-cycle controller and the ALU control unit:
// state encoding, supported opcodes, ALU operation codes and the control word.
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADDR   = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECUTE   = 4'd6,
    S_RCOMPLETE = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // 2'b11 is reserved and never produced by the controller.
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    alu_op_t    alu_op;
  } ctrl_t;

  // Loads and stores share the address-calculation state.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Datapath-facing bundle of the multi-cycle controller. The datapath side
// (master) supplies the opcode and memory handshake; the controller (slave)
// returns the control word plus debug/status outputs.
interface multi_cycle_control_if;
  logic [5:0]  Opcode;
  logic        MemReady;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        IorD;
  logic        MemRead;
  logic        MemWrite;
  logic        MemToReg;
  logic        IRWrite;
  logic        ALUSrcA;
  logic        RegWrite;
  logic        RegDst;
  logic [1:0]  PCSource;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ALUOperation;
  logic [3:0]  StateOut;
  logic        IllegalOp;
  logic [31:0] InstrCount;

  modport master (
    output Opcode, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite,
    input  ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOperation,
    input  StateOut, IllegalOp, InstrCount
  );

  modport slave (
    input  Opcode, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite,
    output ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOperation,
    output StateOut, IllegalOp, InstrCount
  );
endinterface

// File: rtl/control_output_decoder.sv
// Combinational state-to-control-word decode. Only FETCH looks at MemReady,
// so the instruction register and PC update exactly when the fetch completes.
module control_output_decoder
  import control_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Everything defaults to 0; each state raises only its own controls.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMREAD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RCOMPLETE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style main controller: state register, next-state logic,
// sticky illegal-opcode flag and completed-fetch counter.
module multi_cycle_control
  import control_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  multi_cycle_control_if.slave bus
);

  state_t      state_reg;
  logic        illegal_reg;
  logic [31:0] instr_count_reg;
  ctrl_t       ctrl;

  // Sequencing; reset wins over MemReady and Opcode on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_FETCH;
      illegal_reg     <= 1'b0;
      instr_count_reg <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (bus.MemReady) begin
            state_reg       <= S_DECODE;
            instr_count_reg <= instr_count_reg + 32'd1;
          end
        end
        S_DECODE: begin
          if (is_mem_op(bus.Opcode)) begin
            state_reg <= S_MEMADDR;
          end else begin
            case (bus.Opcode)
              OP_RTYPE: state_reg <= S_EXECUTE;
              OP_BEQ:   state_reg <= S_BRANCH;
              OP_J:     state_reg <= S_JUMP;
              default: begin
                state_reg   <= S_FETCH;
                illegal_reg <= 1'b1;
              end
            endcase
          end
        end
        // Opcode is held stable through the instruction, so lw/sw split here.
        S_MEMADDR:   state_reg <= (bus.Opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:   if (bus.MemReady) state_reg <= S_MEMWB;
        S_MEMWRITE:  if (bus.MemReady) state_reg <= S_FETCH;
        S_EXECUTE:   state_reg <= S_RCOMPLETE;
        S_MEMWB,
        S_RCOMPLETE,
        S_BRANCH,
        S_JUMP:      state_reg <= S_FETCH;
        // Codes 10-15 are unreachable in normal operation; recover to FETCH.
        default:     state_reg <= S_FETCH;
      endcase
    end
  end

  control_output_decoder u_decoder (
    .state     (state_reg),
    .mem_ready (bus.MemReady),
    .ctrl      (ctrl)
  );

  assign bus.PCWrite      = ctrl.pc_write;
  assign bus.PCWriteCond  = ctrl.pc_write_cond;
  assign bus.IorD         = ctrl.i_or_d;
  assign bus.MemRead      = ctrl.mem_read;
  assign bus.MemWrite     = ctrl.mem_write;
  assign bus.MemToReg     = ctrl.mem_to_reg;
  assign bus.IRWrite      = ctrl.ir_write;
  assign bus.ALUSrcA      = ctrl.alu_src_a;
  assign bus.RegWrite     = ctrl.reg_write;
  assign bus.RegDst       = ctrl.reg_dst;
  assign bus.PCSource     = ctrl.pc_source;
  assign bus.ALUSrcB      = ctrl.alu_src_b;
  assign bus.ALUOperation = ctrl.alu_op;
  assign bus.StateOut     = state_reg;
  assign bus.IllegalOp    = illegal_reg;
  assign bus.InstrCount   = instr_count_reg;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: a per-cycle vector table walks
// lw, sw (with memory waits), beq, j, R-type and illegal opcodes, followed by
// hand-written reset and counter-wrap sequences.
module tb_multi_cycle_control;

  logic clk = 1'b0;
  logic reset;

  multi_cycle_control_if bus();

  multi_cycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected control words, packed as
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemToReg,IRWrite,ALUSrcA,
  //  RegWrite,RegDst,PCSource[1:0],ALUSrcB[1:0],ALUOperation[1:0]}
  localparam logic [15:0] C_FETCH_R = 16'b1001001000_00_01_00;
  localparam logic [15:0] C_FETCH_W = 16'b0001000000_00_01_00;
  localparam logic [15:0] C_DECODE  = 16'b0000000000_00_11_00;
  localparam logic [15:0] C_MEMADDR = 16'b0000000100_00_10_00;
  localparam logic [15:0] C_MEMREAD = 16'b0011000000_00_00_00;
  localparam logic [15:0] C_MEMWB   = 16'b0000010010_00_00_00;
  localparam logic [15:0] C_MEMWR   = 16'b0010100000_00_00_00;
  localparam logic [15:0] C_EXECUTE = 16'b0000000100_00_00_10;
  localparam logic [15:0] C_RCOMP   = 16'b0000000011_00_00_00;
  localparam logic [15:0] C_BRANCH  = 16'b0100000100_01_00_01;
  localparam logic [15:0] C_JUMP    = 16'b1000000000_10_00_00;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100, JP = 6'b000010, IL = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        ill;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int tests = 0;
  int fails = 0;

  function automatic logic [15:0] act_ctrl();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.MemToReg, bus.IRWrite, bus.ALUSrcA, bus.RegWrite, bus.RegDst,
            bus.PCSource, bus.ALUSrcB, bus.ALUOperation};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st,
                     input logic [15:0] c, input logic ill, input logic [31:0] cnt);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st; v.ctrl = c; v.ill = ill; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    // Per-cycle table: inputs for the cycle and the outputs expected in it.
    // lw, MemReady high throughout: 0,1,2,3,4,0
    add(LW, 1, 0, C_FETCH_R, 0, 0);
    add(LW, 1, 1, C_DECODE,  0, 1);
    add(LW, 1, 2, C_MEMADDR, 0, 1);
    add(LW, 1, 3, C_MEMREAD, 0, 1);
    add(LW, 1, 4, C_MEMWB,   0, 1);
    add(SW, 0, 0, C_FETCH_W, 0, 1);
    // sw with three wait cycles in MEMWRITE
    add(SW, 1, 0, C_FETCH_R, 0, 1);
    add(SW, 1, 1, C_DECODE,  0, 2);
    add(SW, 0, 2, C_MEMADDR, 0, 2);
    add(SW, 0, 5, C_MEMWR,   0, 2);
    add(SW, 0, 5, C_MEMWR,   0, 2);
    add(SW, 0, 5, C_MEMWR,   0, 2);
    add(SW, 1, 5, C_MEMWR,   0, 2);
    // beq: ALUOperation 00,00,01
    add(BQ, 1, 0, C_FETCH_R, 0, 2);
    add(BQ, 1, 1, C_DECODE,  0, 3);
    add(BQ, 1, 8, C_BRANCH,  0, 3);
    // j
    add(JP, 1, 0, C_FETCH_R, 0, 3);
    add(JP, 1, 1, C_DECODE,  0, 4);
    add(JP, 1, 9, C_JUMP,    0, 4);
    // R-type
    add(RT, 1, 0, C_FETCH_R, 0, 4);
    add(RT, 1, 1, C_DECODE,  0, 5);
    add(RT, 1, 6, C_EXECUTE, 0, 5);
    add(RT, 1, 7, C_RCOMP,   0, 5);
    // illegal opcode: 0,1,0 and sticky flag
    add(IL, 1, 0, C_FETCH_R, 0, 5);
    add(IL, 1, 1, C_DECODE,  0, 6);
    add(RT, 1, 0, C_FETCH_R, 1, 6);
    add(RT, 1, 1, C_DECODE,  1, 7);
    add(RT, 1, 6, C_EXECUTE, 1, 7);
    add(RT, 1, 7, C_RCOMP,   1, 7);
    add(IL, 1, 0, C_FETCH_R, 1, 7);
    add(IL, 1, 1, C_DECODE,  1, 8);
    add(IL, 0, 0, C_FETCH_W, 1, 8);

    // Reset with MemReady low, then check reset state.
    reset = 1'b1;
    bus.Opcode = RT;
    bus.MemReady = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_state", {28'd0, bus.StateOut}, 32'd0);
    chk("reset_ctrl", {16'd0, act_ctrl()}, {16'd0, C_FETCH_W});
    chk("reset_illegal", {31'd0, bus.IllegalOp}, 32'd0);
    chk("reset_count", bus.InstrCount, 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.Opcode = vecs[i].op;
      bus.MemReady = vecs[i].mr;
      #1;
      chk($sformatf("vec%0d_state", i), {28'd0, bus.StateOut}, {28'd0, vecs[i].st});
      chk($sformatf("vec%0d_ctrl", i), {16'd0, act_ctrl()}, {16'd0, vecs[i].ctrl});
      chk($sformatf("vec%0d_illegal", i), {31'd0, bus.IllegalOp}, {31'd0, vecs[i].ill});
      chk($sformatf("vec%0d_count", i), bus.InstrCount, vecs[i].cnt);
      $display("[TB] vec %0d op=%b mr=%0d state=%0d ctrl=%b ill=%0d cnt=%0d",
               i, vecs[i].op, vecs[i].mr, bus.StateOut, act_ctrl(), bus.IllegalOp, bus.InstrCount);
    end

    // Reset during a FETCH wait, with MemReady raised on the same edge:
    // reset must win, leaving FETCH and a zero count; IllegalOp clears.
    @(negedge clk);
    reset = 1'b1;
    bus.MemReady = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.MemReady = 1'b0;
    #1;
    chk("rst_fetchwait_state", {28'd0, bus.StateOut}, 32'd0);
    chk("rst_fetchwait_count", bus.InstrCount, 32'd0);
    chk("rst_fetchwait_illegal", {31'd0, bus.IllegalOp}, 32'd0);
    $display("[TB] reset in fetch wait: state=%0d cnt=%0d ill=%0d",
             bus.StateOut, bus.InstrCount, bus.IllegalOp);

    // Reset during a MEMREAD wait.
    bus.Opcode = LW;
    bus.MemReady = 1'b1;
    repeat (3) @(negedge clk);
    bus.MemReady = 1'b0;
    #1;
    chk("lw_wait_state", {28'd0, bus.StateOut}, 32'd3);
    @(negedge clk);
    chk("lw_wait_hold", {28'd0, bus.StateOut}, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_memwait_state", {28'd0, bus.StateOut}, 32'd0);
    chk("rst_memwait_count", bus.InstrCount, 32'd0);
    $display("[TB] reset in memread wait: state=%0d cnt=%0d", bus.StateOut, bus.InstrCount);

    // Illegal opcode sets the flag; reset in DECODE with an illegal opcode
    // present must leave it clear.
    bus.Opcode = IL;
    bus.MemReady = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.MemReady = 1'b0;
    #1;
    chk("rst_decode_illegal", {31'd0, bus.IllegalOp}, 32'd0);
    chk("rst_decode_state", {28'd0, bus.StateOut}, 32'd0);

    // Counter wrap: preload all-ones, one completed fetch gives zero.
    @(negedge clk);
    force dut.instr_count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.instr_count_reg;
    #1;
    chk("wrap_preload", bus.InstrCount, 32'hFFFF_FFFF);
    bus.Opcode = RT;
    bus.MemReady = 1'b1;
    @(negedge clk);
    #1;
    chk("wrap_count", bus.InstrCount, 32'd0);
    chk("wrap_state", {28'd0, bus.StateOut}, 32'd1);
    $display("[TB] wrap: cnt=0x%0h state=%0d", bus.InstrCount, bus.StateOut);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 clk  input  1  single system clock; all state changes occur on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 Opcode  input  6  instruction bits [31:26] from the instruction register; stable from DECODE until the next FETCH.
REQ-004 MemReady  input  1  memory access complete in the current cycle.
REQ-005 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls.
REQ-006 PCSource, ALUSrcB  output  2 each  datapath mux selects.
REQ-007 ALUOperation  output  2  feeds the ALU control unit: 00 = add, 01 = subtract, 10 = decode the funct field; 11 is never driven.
REQ-008 StateOut  output  4  current state code, for debug.
REQ-009 IllegalOp  output  1  sticky flag for an unsupported opcode.
REQ-010 InstrCount  output  32  count of completed instruction fetches.

Function
REQ-011 State codes SHALL be: FETCH 0, DECODE 1, MEMADDR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, RCOMPLETE 7, BRANCH 8, JUMP 9.
REQ-012 Outputs SHALL be decoded from the current state only, except IRWrite and PCWrite in FETCH, which SHALL equal MemReady.
REQ-013 Any output not listed for a state SHALL be 0.
REQ-014 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOperation=00, PCSource=00 and IRWrite=PCWrite=MemReady.
REQ-015 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOperation=00.
REQ-016 MEMADDR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOperation=00.
REQ-017 MEMREAD SHALL drive MemRead=1, IorD=1; MEMWRITE SHALL drive MemWrite=1, IorD=1.
REQ-018 MEMWB SHALL drive RegWrite=1, MemToReg=1, RegDst=0.
REQ-019 EXECUTE SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOperation=10.
REQ-020 RCOMPLETE SHALL drive RegWrite=1, RegDst=1, MemToReg=0.
REQ-021 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOperation=01, PCWriteCond=1, PCSource=01.
REQ-022 JUMP SHALL drive PCWrite=1, PCSource=10.
REQ-023 FETCH SHALL go to DECODE when MemReady=1 and otherwise hold, with no limit on wait length.
REQ-024 DECODE SHALL branch on Opcode: 100011 (lw) or 101011 (sw) -> MEMADDR; 000000 -> EXECUTE; 000100 -> BRANCH; 000010 -> JUMP; any other -> FETCH and set IllegalOp.
REQ-025 MEMADDR SHALL go to MEMREAD for lw and to MEMWRITE for sw.
REQ-026 MEMREAD SHALL go to MEMWB when MemReady=1 and otherwise hold.
REQ-027 MEMWRITE SHALL go to FETCH when MemReady=1 and otherwise hold.
REQ-028 MEMWB, EXECUTE->RCOMPLETE, RCOMPLETE, BRANCH and JUMP SHALL take one cycle each; MEMWB, RCOMPLETE, BRANCH and JUMP return to FETCH.
REQ-029 Unused state codes 10-15 SHALL go to FETCH on the next edge.
REQ-030 InstrCount SHALL increment by 1 on each edge where the state is FETCH and MemReady=1, wrapping from 0xFFFFFFFF to 0.
REQ-031 Instruction latency SHALL be (cycles excluding memory waits): lw 5, sw 4, R-type 4, beq 3, j 3, illegal 2.
REQ-032 IllegalOp SHALL stay at 1 until reset once set; a later illegal opcode has no further effect.

Reset
REQ-033 On an edge with reset=1: state -> FETCH, IllegalOp -> 0, InstrCount -> 0, from any state including a memory wait.
REQ-034 After reset all outputs SHALL take the FETCH values: MemRead=1, IRWrite=PCWrite=MemReady, StateOut=0, all others 0.
REQ-035 Reset SHALL take priority over MemReady and Opcode on the same edge.

Structure
REQ-036 State codes, the five opcode constants and the ALUOperation codes SHALL live in a shared package, control_pkg, also used by the ALU control unit.
REQ-037 State-to-control-word decode SHALL be a combinational sub-module, control_output_decoder.
REQ-038 The state register, next-state logic and counters SHALL live in the top module.

Verification
REQ-039 Reset, then lw (100011) with MemReady=1 throughout -> states 0,1,2,3,4,0; RegWrite=1 only in state 4; InstrCount=1.
REQ-040 sw (101011) with MemReady held 0 for 3 cycles in MEMWRITE -> state 5 for 4 cycles, MemWrite=1 throughout, then state 0.
REQ-041 beq (000100) -> ALUOperation 00,00,01 across states 0,1,8; PCWriteCond=1 only in state 8.
REQ-042 Opcode 111111 -> states 0,1,0; IllegalOp=1 and still 1 after a following R-type; cleared by reset.
REQ-043 reset asserted during a FETCH wait (MemReady=0) -> next state 0, InstrCount=0; InstrCount preloaded to 0xFFFFFFFF then one fetch -> 0.
